hazard_stall_ctrl: RTL

//  Pipeline sequencer for the 5-stage MIPS core. Compares D-stage operand demand (Tuse) against
//  E/M producer readiness (Tnew) and tracks the HI/LO mult/div unit busy window. Drives the

---
 rtl/hazard_stall_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// ============================================================================
// hazard_stall_ctrl : Tuse/Tnew and mult/div-busy stall control for a 5-stage MIPS pipeline
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rs_D,
   input  logic [4:0]  rt_D,
   input  logic [1:0]  Tuse_rs,
   input  logic [1:0]  Tuse_rt,
   input  logic        RegWrite_E,
   input  logic [4:0]  regWA_E,
   input  logic [1:0]  Tnew_E,
   input  logic        RegWrite_M,
   input  logic [4:0]  regWA_M,
   input  logic [1:0]  Tnew_M,
   input  logic        md_start_E,
   input  logic        md_is_div_E,
   input  logic        md_use_D,
   output logic        en01,
   output logic        en12,
   output logic        flush12,
   output logic        en23,
   output logic        en34,
   output logic        md_busy,
   output logic [31:0] stall_cnt
);

   localparam logic [CNT_W-1:0] c_mult_cnt = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] c_div_cnt  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } md_state_t;

   md_state_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_stall_cnt;

   logic w_hz_rs_e, w_hz_rs_m, w_hz_rt_e, w_hz_rt_m;
   logic w_md_hz, w_stall;

   // $0 is hard-wired zero, so it can never be a real dependency
   assign w_hz_rs_e = RegWrite_E && (regWA_E == rs_D) && (rs_D != 5'd0) && (Tuse_rs < Tnew_E);
   assign w_hz_rs_m = RegWrite_M && (regWA_M == rs_D) && (rs_D != 5'd0) && (Tuse_rs < Tnew_M);
   assign w_hz_rt_e = RegWrite_E && (regWA_E == rt_D) && (rt_D != 5'd0) && (Tuse_rt < Tnew_E);
   assign w_hz_rt_m = RegWrite_M && (regWA_M == rt_D) && (rt_D != 5'd0) && (Tuse_rt < Tnew_M);

   assign w_md_hz = md_use_D && ((r_state == S_BUSY) || md_start_E);
   assign w_stall = (w_hz_rs_e || w_hz_rs_m || w_hz_rt_e || w_hz_rt_m || w_md_hz) && !reset;

   // Stalls insert a bubble at D/E; downstream registers keep flowing
   assign en01      = !w_stall;
   assign flush12   = w_stall;
   assign en12      = 1'b1;
   assign en23      = 1'b1;
   assign en34      = 1'b1;
   assign md_busy   = (r_state == S_BUSY);
   assign stall_cnt = r_stall_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_stall_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (md_start_E) begin
                  r_state <= S_BUSY;
                  r_cnt   <= md_is_div_E ? c_div_cnt : c_mult_cnt;
               end
            end
            S_BUSY: begin
               if (r_cnt == c_cnt_one) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt - c_cnt_one;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
         endcase
         if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF))
            r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

endmodule

`default_nettype wire
